// File: rtl/midi_note_parser_if.sv
// midi_note_parser_if
// Purpose: groups the byte stream coming from the UART receiver and the
// decoded note outputs of the MIDI parser into a single bundle.
// Signals:
//   byte_i         received MIDI byte
//   byte_valid_i   single-cycle strobe qualifying byte_i (no backpressure)
//   event_valid_o  one-cycle strobe for a decoded note event
//   event_on_o     1 = note on, 0 = note off (qualified by event_valid_o)
//   note_o         note number of the last event
//   velocity_o     velocity of the last event (0 for note off)
//   gate_o         a note is currently held (mono, last-note priority)
//   active_note_o  currently held or last released note
// Modports:
//   master  byte source side (UART / testbench), observes the decoded outputs
//   slave   parser side
interface midi_note_parser_if #(
  parameter int MIDI_BITS = 7
);
  logic [7:0]           byte_i;
  logic                 byte_valid_i;
  logic                 event_valid_o;
  logic                 event_on_o;
  logic [MIDI_BITS-1:0] note_o;
  logic [MIDI_BITS-1:0] velocity_o;
  logic                 gate_o;
  logic [MIDI_BITS-1:0] active_note_o;

  modport master (
    output byte_i, byte_valid_i,
    input  event_valid_o, event_on_o, note_o, velocity_o, gate_o, active_note_o
  );

  modport slave (
    input  byte_i, byte_valid_i,
    output event_valid_o, event_on_o, note_o, velocity_o, gate_o, active_note_o
  );
endinterface

// File: rtl/midi_note_parser.sv
// midi_note_parser
// Purpose: byte-level MIDI receive parser. Decodes Note On / Note Off for one
// channel (or every channel when OMNI=1), honouring running status, realtime
// bytes interleaved anywhere, and system messages that cancel running status.
// Produces a one-cycle note event plus a monophonic last-note gate whose held
// note feeds the band mapping stage.
// Parameters:
//   MIDI_BITS  width of note / velocity fields (at most 7)
//   CHANNEL    MIDI channel 0-15 accepted when OMNI=0
//   OMNI       1 = accept note messages on every channel
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   bus        midi_note_parser_if slave: byte stream in, note events out
module midi_note_parser #(
  parameter int MIDI_BITS = 7,
  parameter int CHANNEL   = 0,
  parameter int OMNI      = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  midi_note_parser_if.slave     bus
);

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    D1        = 2'd1,
    D2        = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;

  logic [3:0]           r_rsType;
  logic                 r_rsMatch;
  logic                 r_rsValid;
  logic [MIDI_BITS-1:0] r_d1;

  logic                 r_evValid;
  logic                 r_evOn;
  logic [MIDI_BITS-1:0] r_note;
  logic [MIDI_BITS-1:0] r_velocity;
  logic                 r_gate;
  logic [MIDI_BITS-1:0] r_activeNote;

  logic [7:0]           w_byte;
  logic [MIDI_BITS-1:0] w_data;
  logic                 w_isRealtime;
  logic                 w_isSystem;
  logic                 w_isStatus;
  logic                 w_isData;
  logic                 w_chanMatch;
  logic                 w_oneDataByte;
  logic                 w_storeD1;
  logic                 w_complete;
  logic                 w_fire;
  logic                 w_fireOn;

  assign w_byte = bus.byte_i;
  assign w_data = w_byte[MIDI_BITS-1:0];

  // Byte classification; all classes are qualified by the valid strobe so an
  // idle bus can never move the parser.
  assign w_isRealtime = bus.byte_valid_i && (w_byte[7:3] == 5'b11111);
  assign w_isSystem   = bus.byte_valid_i && (w_byte[7:3] == 5'b11110);
  assign w_isStatus   = bus.byte_valid_i && w_byte[7] && (w_byte[7:4] != 4'hF);
  assign w_isData     = bus.byte_valid_i && !w_byte[7];

  assign w_chanMatch   = (OMNI != 0) || (w_byte[3:0] == 4'(CHANNEL));
  // Program change and channel pressure carry a single data byte.
  assign w_oneDataByte = (r_rsType == 4'hC) || (r_rsType == 4'hD);

  // Next-state logic. A completed message always returns to D1 so that a
  // following data byte reuses the running status.
  always_comb begin
    w_stateNext = r_state;
    w_storeD1   = 1'b0;
    w_complete  = 1'b0;
    if (w_isSystem) begin
      w_stateNext = NO_STATUS;
    end else if (w_isStatus) begin
      w_stateNext = D1;
    end else if (w_isData) begin
      unique case (r_state)
        NO_STATUS: w_stateNext = NO_STATUS;
        D1: begin
          w_storeD1 = 1'b1;
          if (w_oneDataByte) begin
            w_complete  = 1'b1;
            w_stateNext = D1;
          end else begin
            w_stateNext = D2;
          end
        end
        D2: begin
          w_complete  = 1'b1;
          w_stateNext = D1;
        end
        default: w_stateNext = NO_STATUS;
      endcase
    end
  end

  // Only two-byte note messages can fire, so the event note is always the
  // stored first data byte and the current byte is the velocity.
  assign w_fire   = w_complete && r_rsValid && r_rsMatch &&
                    ((r_rsType == 4'h8) || (r_rsType == 4'h9));
  assign w_fireOn = (r_rsType == 4'h9) && (w_data != '0);

  // Parser state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= NO_STATUS;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Running status and first data byte capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsType  <= 4'h0;
      r_rsMatch <= 1'b0;
      r_rsValid <= 1'b0;
      r_d1      <= '0;
    end else begin
      if (w_isSystem) begin
        r_rsType  <= 4'h0;
        r_rsMatch <= 1'b0;
        r_rsValid <= 1'b0;
      end else if (w_isStatus) begin
        r_rsType  <= w_byte[7:4];
        r_rsMatch <= w_chanMatch;
        r_rsValid <= 1'b1;
      end
      if (w_storeD1) begin
        r_d1 <= w_data;
      end
    end
  end

  // Event outputs and mono last-note tracking. A note off only releases the
  // gate when it names the note currently sounding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_evValid    <= 1'b0;
      r_evOn       <= 1'b0;
      r_note       <= '0;
      r_velocity   <= '0;
      r_gate       <= 1'b0;
      r_activeNote <= '0;
    end else begin
      r_evValid <= w_fire;
      if (w_fire) begin
        r_evOn     <= w_fireOn;
        r_note     <= r_d1;
        r_velocity <= w_fireOn ? w_data : '0;
        if (w_fireOn) begin
          r_gate       <= 1'b1;
          r_activeNote <= r_d1;
        end else if (r_d1 == r_activeNote) begin
          r_gate <= 1'b0;
        end
      end
    end
  end

  assign bus.event_valid_o = r_evValid;
  assign bus.event_on_o    = r_evOn;
  assign bus.note_o        = r_note;
  assign bus.velocity_o    = r_velocity;
  assign bus.gate_o        = r_gate;
  assign bus.active_note_o = r_activeNote;

endmodule

// File: tb/tb_midi_note_parser.sv
// tb_midi_note_parser
// Purpose: self-checking bench for midi_note_parser. One instance listens on
// channel 0, a second instance runs in omni mode on the same byte stream.
// A table of per-byte vectors carries the expected outputs after each byte;
// reset-related corner cases are driven as hand-written sequences.
module tb_midi_note_parser;

  logic clk;
  logic rst;

  midi_note_parser_if #(.MIDI_BITS(7)) busCh0 ();
  midi_note_parser_if #(.MIDI_BITS(7)) busOmni ();

  midi_note_parser #(.MIDI_BITS(7), .CHANNEL(0), .OMNI(0)) dutCh0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busCh0.slave)
  );

  midi_note_parser #(.MIDI_BITS(7), .CHANNEL(0), .OMNI(1)) dutOmni (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (busOmni.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] b;
    logic       ev;
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    logic       gate;
    logic [6:0] act;
    logic       omniEv;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nBad    = 0;

  function automatic vec_t mk(logic vld, logic [7:0] b, logic ev, logic on,
                              int note, int vel, logic gate, int act,
                              logic omniEv);
    vec_t v;
    v.vld    = vld;
    v.b      = b;
    v.ev     = ev;
    v.on     = on;
    v.note   = 7'(note);
    v.vel    = 7'(vel);
    v.gate   = gate;
    v.act    = 7'(act);
    v.omniEv = omniEv;
    return v;
  endfunction

  // Drive one byte (or an idle cycle) to both instances at the falling edge,
  // then return #1 after the rising edge that accepted it.
  task automatic applyStimulus(input logic vld, input logic [7:0] b);
    @(negedge clk);
    busCh0.byte_i        = b;
    busCh0.byte_valid_i  = vld;
    busOmni.byte_i       = b;
    busOmni.byte_valid_i = vld;
    @(posedge clk);
    #1;
    busCh0.byte_valid_i  = 1'b0;
    busOmni.byte_valid_i = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, " event_valid"}, int'(busCh0.event_valid_o), int'(v.ev));
    if (v.ev) begin
      checkOutput({tag, " event_on"}, int'(busCh0.event_on_o), int'(v.on));
      checkOutput({tag, " note"}, int'(busCh0.note_o), int'(v.note));
      checkOutput({tag, " velocity"}, int'(busCh0.velocity_o), int'(v.vel));
    end
    checkOutput({tag, " gate"}, int'(busCh0.gate_o), int'(v.gate));
    checkOutput({tag, " active_note"}, int'(busCh0.active_note_o), int'(v.act));
    checkOutput({tag, " omni event_valid"}, int'(busOmni.event_valid_o), int'(v.omniEv));
    if (v.omniEv) begin
      checkOutput({tag, " omni note"}, int'(busOmni.note_o), int'(v.note));
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #2;
    checkOutput("async reset event_valid", int'(busCh0.event_valid_o), 0);
    checkOutput("async reset gate", int'(busCh0.gate_o), 0);
    checkOutput("async reset active_note", int'(busCh0.active_note_o), 0);
    checkOutput("async reset note", int'(busCh0.note_o), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst                  = 1'b1;
    busCh0.byte_i        = 8'h00;
    busCh0.byte_valid_i  = 1'b0;
    busOmni.byte_i       = 8'h00;
    busOmni.byte_valid_i = 1'b0;

    // Data byte with no status yet is discarded.
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0,   0, 0,  0, 0));
    // Single note on, followed by an idle cycle.
    vecs.push_back(mk(1, 8'h90, 0, 0,  0,   0, 0,  0, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0,   0, 0,  0, 0));
    vecs.push_back(mk(1, 8'h64, 1, 1, 60, 100, 1, 60, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0,   0, 1, 60, 0));
    // Running status: on 64, then velocity-0 off 64.
    vecs.push_back(mk(1, 8'h90, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h40, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h50, 1, 1, 64,  80, 1, 64, 1));
    vecs.push_back(mk(1, 8'h40, 0, 0,  0,   0, 1, 64, 0));
    vecs.push_back(mk(1, 8'h00, 1, 0, 64,   0, 0, 64, 1));
    // Realtime bytes interleaved inside a message.
    vecs.push_back(mk(1, 8'h90, 0, 0,  0,   0, 0, 64, 0));
    vecs.push_back(mk(1, 8'hF8, 0, 0,  0,   0, 0, 64, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0,   0, 0, 64, 0));
    vecs.push_back(mk(1, 8'hFE, 0, 0,  0,   0, 0, 64, 0));
    vecs.push_back(mk(1, 8'h64, 1, 1, 60, 100, 1, 60, 1));
    // System common mid-message cancels running status.
    vecs.push_back(mk(1, 8'h90, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'hF0, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h64, 0, 0,  0,   0, 1, 60, 0));
    // Channel 1 note on: ignored on channel 0, seen in omni.
    vecs.push_back(mk(1, 8'h91, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0, 60,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h64, 0, 0, 60,   0, 1, 60, 1));
    // Release 60 with a note off status.
    vecs.push_back(mk(1, 8'h80, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h00, 1, 0, 60,   0, 0, 60, 1));
    // Mono priority: on 60, on 64 (running), off 60, off 64 (running).
    vecs.push_back(mk(1, 8'h90, 0, 0,  0,   0, 0, 60, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0,   0, 0, 60, 0));
    vecs.push_back(mk(1, 8'h40, 1, 1, 60,  64, 1, 60, 1));
    vecs.push_back(mk(1, 8'h40, 0, 0,  0,   0, 1, 60, 0));
    vecs.push_back(mk(1, 8'h40, 1, 1, 64,  64, 1, 64, 1));
    vecs.push_back(mk(1, 8'h80, 0, 0,  0,   0, 1, 64, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0,   0, 1, 64, 0));
    vecs.push_back(mk(1, 8'h40, 1, 0, 60,   0, 1, 64, 1));
    vecs.push_back(mk(1, 8'h40, 0, 0,  0,   0, 1, 64, 0));
    vecs.push_back(mk(1, 8'h40, 1, 0, 64,   0, 0, 64, 1));
    // One-data-byte program change, then a note on.
    vecs.push_back(mk(1, 8'hC0, 0, 0,  0,   0, 0, 64, 0));
    vecs.push_back(mk(1, 8'h05, 0, 0,  0,   0, 0, 64, 0));
    vecs.push_back(mk(1, 8'h90, 0, 0,  0,   0, 0, 64, 0));
    vecs.push_back(mk(1, 8'h3C, 0, 0,  0,   0, 0, 64, 0));
    vecs.push_back(mk(1, 8'h64, 1, 1, 60, 100, 1, 60, 1));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset event_valid", int'(busCh0.event_valid_o), 0);
    checkOutput("reset event_on", int'(busCh0.event_on_o), 0);
    checkOutput("reset note", int'(busCh0.note_o), 0);
    checkOutput("reset velocity", int'(busCh0.velocity_o), 0);
    checkOutput("reset gate", int'(busCh0.gate_o), 0);
    checkOutput("reset active_note", int'(busCh0.active_note_o), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].vld, vecs[i].b);
      checkVector(i, vecs[i]);
    end

    // Control change cut short by reset; a stray data byte must not complete it.
    applyStimulus(1'b1, 8'hB0);
    applyStimulus(1'b1, 8'h07);
    pulseReset();
    applyStimulus(1'b1, 8'h64);
    checkOutput("post-reset cc event_valid", int'(busCh0.event_valid_o), 0);
    checkOutput("post-reset cc gate", int'(busCh0.gate_o), 0);

    // Note on cut short by reset before its velocity byte.
    applyStimulus(1'b1, 8'h90);
    applyStimulus(1'b1, 8'h3C);
    pulseReset();
    applyStimulus(1'b1, 8'h64);
    checkOutput("post-reset note event_valid", int'(busCh0.event_valid_o), 0);
    checkOutput("post-reset omni event_valid", int'(busOmni.event_valid_o), 0);
    checkOutput("post-reset note gate", int'(busCh0.gate_o), 0);

    // Parser is fully alive after reset.
    applyStimulus(1'b1, 8'h90);
    applyStimulus(1'b1, 8'h3E);
    applyStimulus(1'b1, 8'h7F);
    checkOutput("recovery event_valid", int'(busCh0.event_valid_o), 1);
    checkOutput("recovery note", int'(busCh0.note_o), 62);
    checkOutput("recovery velocity", int'(busCh0.velocity_o), 127);
    checkOutput("recovery active_note", int'(busCh0.active_note_o), 62);
    applyStimulus(1'b0, 8'h00);
    checkOutput("recovery strobe width", int'(busCh0.event_valid_o), 0);
    checkOutput("recovery held note", int'(busCh0.note_o), 62);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
